mult_unit: RTL

MULT_UNIT -- requirements
Module: mult_unit

---
 rtl/mult_unit_pkg.sv | 17 +
 rtl/mult_step.sv | 19 +
 rtl/mult_unit.sv | 125 ++++++++++++
 3 files changed

// File: rtl/mult_unit_pkg.sv
// Shared definitions for the shift-and-add multiplier: FSM encoding, data width
// and the register index that must never be written by a multiply (PC).
package mult_unit_pkg;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 5;

  localparam logic [CNT_W-1:0] CNT_MAX = 5'd31;
  localparam logic [3:0]       REG_PC  = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mult_step.sv
// One iteration of the shift-and-add multiply: conditional add of the
// multiplicand, then shift multiplicand left and multiplier right.
module mult_step
  import mult_unit_pkg::*;
(
  input  logic [DATA_W-1:0] product,
  input  logic [DATA_W-1:0] mcand,
  input  logic [DATA_W-1:0] mplier,
  output logic [DATA_W-1:0] product_next,
  output logic [DATA_W-1:0] mcand_next,
  output logic [DATA_W-1:0] mplier_next
);

  // Sum wraps modulo 2^32, so signed and unsigned operands give the same low word.
  assign product_next = mplier[0] ? (product + mcand) : product;
  assign mcand_next   = mcand << 1;
  assign mplier_next  = mplier >> 1;

endmodule

// File: rtl/mult_unit.sv
// Iterative MUL/MLA unit: one bit of the multiplier per RUN cycle with early
// exit once the remaining multiplier is zero; result presented for one cycle.
module mult_unit
  import mult_unit_pkg::*;
(
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              i_start,
  input  logic [DATA_W-1:0] i_op_a,
  input  logic [DATA_W-1:0] i_op_b,
  input  logic [DATA_W-1:0] i_acc,
  input  logic              i_accumulate,
  input  logic [3:0]        i_dest,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_wr_en,
  output logic [3:0]        o_dest,
  output logic [DATA_W-1:0] o_load,
  output logic              o_N,
  output logic              o_Z,
  output logic              o_illegal
);

  state_t            state_reg;
  logic [DATA_W-1:0] product_reg;
  logic [DATA_W-1:0] mcand_reg;
  logic [DATA_W-1:0] mplier_reg;
  logic [CNT_W-1:0]  count_reg;
  logic [3:0]        dest_reg;
  logic              accum_reg;

  logic [DATA_W-1:0] product_next;
  logic [DATA_W-1:0] mcand_next;
  logic [DATA_W-1:0] mplier_next;

  logic              done_reg;
  logic              wr_en_reg;
  logic              illegal_reg;
  logic [3:0]        dest_out_reg;
  logic [DATA_W-1:0] load_reg;
  logic              n_reg;
  logic              z_reg;

  mult_step u_step (
    .product      (product_reg),
    .mcand        (mcand_reg),
    .mplier       (mplier_reg),
    .product_next (product_next),
    .mcand_next   (mcand_next),
    .mplier_next  (mplier_next)
  );

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_reg    <= ST_IDLE;
      product_reg  <= '0;
      mcand_reg    <= '0;
      mplier_reg   <= '0;
      count_reg    <= '0;
      dest_reg     <= '0;
      accum_reg    <= 1'b0;
      done_reg     <= 1'b0;
      wr_en_reg    <= 1'b0;
      illegal_reg  <= 1'b0;
      dest_out_reg <= '0;
      load_reg     <= '0;
      n_reg        <= 1'b0;
      z_reg        <= 1'b0;
    end else begin
      // Result outputs are only non-zero for the single DONE cycle.
      done_reg    <= 1'b0;
      wr_en_reg   <= 1'b0;
      illegal_reg <= 1'b0;
      load_reg    <= '0;
      n_reg       <= 1'b0;
      z_reg       <= 1'b0;

      case (state_reg)
        ST_IDLE, ST_DONE: begin
          if (i_start) begin
            mcand_reg   <= i_op_a;
            mplier_reg  <= i_op_b;
            dest_reg    <= i_dest;
            accum_reg   <= i_accumulate;
            product_reg <= i_accumulate ? i_acc : '0;
            count_reg   <= '0;
            state_reg   <= ST_RUN;
          end else begin
            state_reg   <= ST_IDLE;
          end
        end

        ST_RUN: begin
          product_reg <= product_next;
          mcand_reg   <= mcand_next;
          mplier_reg  <= mplier_next;
          count_reg   <= count_reg + 1'b1;
          // count_reg is the pre-increment value, so this caps RUN at 32 cycles.
          if ((mplier_next == '0) || (count_reg == CNT_MAX)) begin
            state_reg    <= ST_DONE;
            done_reg     <= 1'b1;
            load_reg     <= product_next;
            n_reg        <= product_next[DATA_W-1];
            z_reg        <= (product_next == '0);
            dest_out_reg <= dest_reg;
            wr_en_reg    <= (dest_reg != REG_PC);
            illegal_reg  <= (dest_reg == REG_PC);
          end
        end

        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign o_busy    = (state_reg == ST_RUN);
  assign o_done    = done_reg;
  assign o_wr_en   = wr_en_reg;
  assign o_illegal = illegal_reg;
  assign o_dest    = dest_out_reg;
  assign o_load    = load_reg;
  assign o_N       = n_reg;
  assign o_Z       = z_reg;

endmodule
